// File: rtl/bin2bcd_display_feeder_pkg.sv
// Shared definitions for the binary-to-BCD display feeder: FSM encoding and
// conversion limits.
package bin2bcd_display_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest value four BCD digits can show.
    localparam int BCD_MAX = 9999;

    // 100 ms between automatic samples at 50 MHz.
    localparam int SAMPLE_DIV_DEFAULT = 5000000;

endpackage

// File: rtl/bin2bcd_display_feeder_if.sv
// Request/result bundle between a debug-value source and the BCD display feeder.
interface bin2bcd_display_feeder_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] Bin_Value;
    logic             Start_Sig;
    logic             Auto_En;
    logic [15:0]      Number_Sig;
    logic             Busy_Sig;
    logic             Done_Sig;
    logic             Ovf_Sig;

    modport master (
        output Bin_Value, Start_Sig, Auto_En,
        input  Number_Sig, Busy_Sig, Done_Sig, Ovf_Sig
    );

    modport slave (
        input  Bin_Value, Start_Sig, Auto_En,
        output Number_Sig, Busy_Sig, Done_Sig, Ovf_Sig
    );
endinterface

// File: rtl/bin2bcd_display_feeder_bcd_digit_adj3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
module bcd_digit_adj3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end
endmodule

// File: rtl/bin2bcd_display_feeder.sv
// Samples a binary debug value on request or periodic tick, converts it to
// four packed BCD digits by shift-and-add-3, and updates the display word atomically.
module bin2bcd_display_feeder
    import bin2bcd_display_feeder_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
    input logic                     CLK,
    input logic                     RSTn,
    bin2bcd_display_feeder_if.slave bus
);
    localparam int                CNT_W     = $clog2(BIN_W + 1);
    localparam int                TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [BIN_W-1:0]  SAT_VALUE = BIN_W'(BCD_MAX);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(BIN_W);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       number_q, number_d;
    logic              ovf_out_q, ovf_out_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [15:0]       bcd_q, bcd_d;

    logic              tick;
    logic              new_req;
    logic [16:0]       bin_ext;
    logic [15:0]       bcd_adj;
    logic [15:0]       bcd_shift;
    logic [BIN_W-1:0]  bin_shift;

    // Periodic sample tick; held at zero while automatic sampling is off.
    always_comb begin
        tick       = 1'b0;
        tick_cnt_d = '0;
        if (bus.Auto_En) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    assign new_req = bus.Start_Sig | tick;
    assign bin_ext = 17'(bus.Bin_Value);

    for (genvar g = 0; g < 4; g++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    assign bcd_shift = {bcd_adj[14:0], bin_q[BIN_W-1]};
    assign bin_shift = {bin_q[BIN_W-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        bit_cnt_d = bit_cnt_q;
        ovf_d     = ovf_q;
        number_d  = number_q;
        ovf_out_d = ovf_out_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;

        case (state_q)
            IDLE: begin
                if (new_req || pending_q) begin
                    state_d   = LOAD;
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                if (bin_ext > 17'(BCD_MAX)) begin
                    bin_d = SAT_VALUE;
                    ovf_d = 1'b1;
                end else begin
                    bin_d = bus.Bin_Value;
                    ovf_d = 1'b0;
                end
                bcd_d     = '0;
                bit_cnt_d = CNT_INIT;
                pending_d = pending_q | new_req;
                state_d   = SHIFT;
            end
            SHIFT: begin
                bcd_d     = bcd_shift;
                bin_d     = bin_shift;
                // A bit pushed out of the thousands digit means the value outran four digits.
                ovf_d     = ovf_q | bcd_adj[15];
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                pending_d = pending_q | new_req;
                if (bit_cnt_q == CNT_W'(1)) begin
                    // Publish on the edge into DONE so Number_Sig is valid alongside Done_Sig.
                    number_d  = bcd_shift;
                    ovf_out_d = ovf_q | bcd_adj[15];
                    state_d   = DONE;
                end
            end
            DONE: begin
                pending_d = pending_q | new_req;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            pending_q  <= 1'b0;
            bit_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            number_q   <= '0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pending_q  <= pending_d;
            bit_cnt_q  <= bit_cnt_d;
            ovf_q      <= ovf_d;
            number_q   <= number_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    // Working registers are always reloaded in LOAD before use.
    always_ff @(posedge CLK) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
    end

    assign bus.Number_Sig = number_q;
    assign bus.Ovf_Sig    = ovf_out_q;
    assign bus.Busy_Sig   = (state_q != IDLE);
    assign bus.Done_Sig   = (state_q == DONE);

endmodule

// File: tb/tb_bin2bcd_display_feeder.sv
// Directed bench for the BCD display feeder: latency, digit values, saturation,
// request collapsing, periodic sampling and asynchronous reset.
module tb_bin2bcd_display_feeder;
    localparam int BIN_W      = 14;
    localparam int SAMPLE_DIV = 20;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    bin2bcd_display_feeder_if #(.BIN_W(BIN_W)) bus ();

    bin2bcd_display_feeder #(
        .BIN_W      (BIN_W),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int max_steps, output int steps, output bit seen);
        seen  = 1'b0;
        steps = 0;
        while (!seen && steps < max_steps) begin
            step();
            steps++;
            if (bus.Done_Sig === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_one(input logic [BIN_W-1:0] value, output bit seen, output int lat);
        bus.Bin_Value = value;
        bus.Start_Sig = 1'b1;
        step();
        bus.Start_Sig = 1'b0;
        wait_done(40, lat, seen);
        lat = lat + 1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        bus.Bin_Value = '0;
        bus.Start_Sig = 1'b0;
        bus.Auto_En   = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (bus.Number_Sig !== 16'h0000 || bus.Busy_Sig !== 1'b0 ||
            bus.Done_Sig !== 1'b0 || bus.Ovf_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got num=%h busy=%b done=%b ovf=%b expected 0000/0/0/0",
                     bus.Number_Sig, bus.Busy_Sig, bus.Done_Sig, bus.Ovf_Sig);
        end
        RSTn = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic();
        int          busy_cnt = 0;
        int          done_at  = -1;
        int          early    = 0;
        logic [15:0] num_at   = '0;
        logic        ovf_at   = 1'bx;
        bus.Bin_Value = 14'd1234;
        bus.Start_Sig = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (j == 1) bus.Start_Sig = 1'b0;
            if (bus.Busy_Sig === 1'b1) busy_cnt++;
            if (bus.Done_Sig === 1'b1 && done_at < 0) begin
                done_at = j;
                num_at  = bus.Number_Sig;
                ovf_at  = bus.Ovf_Sig;
            end
            if (j < 16 && bus.Number_Sig !== 16'h0000) early++;
        end
        n_cmp++;
        if (done_at != 16) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 16", done_at);
        end
        n_cmp++;
        if (num_at !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_number: got %h expected 1234", num_at);
        end
        n_cmp++;
        if (ovf_at !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ovf: got %b expected 0", ovf_at);
        end
        n_cmp++;
        if (busy_cnt != 16) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected 16", busy_cnt);
        end
        n_cmp++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL basic_no_partial: got %0d early changes expected 0", early);
        end
    endtask

    task automatic test_zero_max();
        bit seen;
        int lat;
        run_one(14'd0, seen, lat);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h0000 || bus.Ovf_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_value: got seen=%b num=%h ovf=%b expected 1/0000/0",
                     seen, bus.Number_Sig, bus.Ovf_Sig);
        end
        step();
        run_one(14'd9999, seen, lat);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h9999 || bus.Ovf_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL max_value: got seen=%b num=%h ovf=%b expected 1/9999/0",
                     seen, bus.Number_Sig, bus.Ovf_Sig);
        end
        step();
        run_one(14'd5, seen, lat);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h0005 || lat != 16) begin
            n_fail++;
            $display("FAIL five_value: got seen=%b num=%h lat=%0d expected 1/0005/16",
                     seen, bus.Number_Sig, lat);
        end
        step();
    endtask

    task automatic test_overflow();
        bit seen;
        int lat;
        run_one(14'd12000, seen, lat);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h9999 || bus.Ovf_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_12000: got seen=%b num=%h ovf=%b expected 1/9999/1",
                     seen, bus.Number_Sig, bus.Ovf_Sig);
        end
        step();
        n_cmp++;
        if (bus.Number_Sig !== 16'h9999 || bus.Ovf_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: got num=%h ovf=%b expected 9999/1", bus.Number_Sig, bus.Ovf_Sig);
        end
        run_one(14'd42, seen, lat);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h0042 || bus.Ovf_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL after_ovf_42: got seen=%b num=%h ovf=%b expected 1/0042/0",
                     seen, bus.Number_Sig, bus.Ovf_Sig);
        end
        step();
        run_one(14'd10000, seen, lat);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h9999 || bus.Ovf_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_10000: got seen=%b num=%h ovf=%b expected 1/9999/1",
                     seen, bus.Number_Sig, bus.Ovf_Sig);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit seen;
        int lat;
        bus.Bin_Value = 14'd250;
        bus.Start_Sig = 1'b1;
        step();
        bus.Start_Sig = 1'b0;
        step();
        // Capture edge has passed; now in SHIFT.
        bus.Bin_Value = 14'd507;
        for (int k = 0; k < 3; k++) begin
            bus.Start_Sig = 1'b1;
            step();
            bus.Start_Sig = 1'b0;
            step();
        end
        wait_done(40, lat, seen);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h0250) begin
            n_fail++;
            $display("FAIL b2b_first: got seen=%b num=%h expected 1/0250", seen, bus.Number_Sig);
        end
        wait_done(40, lat, seen);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h0507 || lat != 17) begin
            n_fail++;
            $display("FAIL b2b_second: got seen=%b num=%h gap=%0d expected 1/0507/17",
                     seen, bus.Number_Sig, lat);
        end
        wait_done(40, lat, seen);
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL b2b_no_third: got done after %0d cycles expected none", lat);
        end
    endtask

    task automatic test_auto();
        int dones[$];
        int bad_num = 0;
        bit seen;
        int lat;
        bus.Bin_Value = 14'd88;
        bus.Auto_En   = 1'b1;
        for (int s = 1; s <= 95; s++) begin
            step();
            if (bus.Done_Sig === 1'b1) begin
                dones.push_back(s);
                if (bus.Number_Sig !== 16'h0088) bad_num++;
            end
        end
        bus.Auto_En = 1'b0;
        n_cmp++;
        if (dones.size() != 4 || dones[0] != 35) begin
            n_fail++;
            $display("FAIL auto_first: got count=%0d first=%0d expected 4/35",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
        n_cmp++;
        if (dones.size() == 4 &&
            (dones[1] - dones[0] != 20 || dones[2] - dones[1] != 20 || dones[3] - dones[2] != 20)) begin
            n_fail++;
            $display("FAIL auto_period: got %0d,%0d,%0d,%0d expected spacing 20",
                     dones[0], dones[1], dones[2], dones[3]);
        end
        n_cmp++;
        if (bad_num != 0) begin
            n_fail++;
            $display("FAIL auto_number: got %0d wrong results expected 0", bad_num);
        end
        wait_done(60, lat, seen);
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL auto_disabled: got done after %0d cycles expected none", lat);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int lat;
        run_one(14'd321, seen, lat);
        n_cmp++;
        if (!seen || bus.Number_Sig !== 16'h0321) begin
            n_fail++;
            $display("FAIL pre_reset_321: got seen=%b num=%h expected 1/0321", seen, bus.Number_Sig);
        end
        step();
        bus.Bin_Value = 14'd777;
        bus.Start_Sig = 1'b1;
        step();
        bus.Start_Sig = 1'b0;
        repeat (5) step();
        RSTn = 1'b0;
        #1;
        n_cmp++;
        if (bus.Number_Sig !== 16'h0000 || bus.Busy_Sig !== 1'b0 || bus.Ovf_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got num=%h busy=%b ovf=%b expected 0000/0/0",
                     bus.Number_Sig, bus.Busy_Sig, bus.Ovf_Sig);
        end
        repeat (2) step();
        RSTn = 1'b1;
        wait_done(40, lat, seen);
        n_cmp++;
        if (seen || bus.Number_Sig !== 16'h0000 || bus.Busy_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got done=%b num=%h busy=%b expected 0/0000/0",
                     seen, bus.Number_Sig, bus.Busy_Sig);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_max();
        test_overflow();
        test_back_to_back();
        test_auto();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
